one_hot_way_pointer: RTL

//  Registered, parametrised one-hot pointer over 2**INPUT_BW slots (cache ways, buffer entries).
//  - Holds the current slot as both one-hot and binary.
//  - Loads from a binary index, or advances circularly to the next eligible (unmasked) slot.
//  - Drives FIFO/round-robin victim selection in the cache controller.
//  - Replaces ad-hoc one_hot_decoder + counter pairs.

---
 rtl/one_hot_way_pointer_pkg.sv | 20 ++
 rtl/one_hot_decoder.sv | 18 +
 rtl/rotate_priority_select.sv | 61 ++++++
 rtl/one_hot_way_pointer.sv | 108 ++++++++++
 4 files changed

// File: rtl/one_hot_way_pointer_pkg.sv
// Shared defaults and helpers for the one-hot way pointer and its users.
// Contents:
//   OHWP_DEFAULT_INPUT_BW  default binary index width
//   ohwp_log2              ceil(log2(n)), used at instantiation sites to
//                          derive INPUT_BW from a way/entry count
package one_hot_way_pointer_pkg;

    localparam int unsigned OHWP_DEFAULT_INPUT_BW = 3;

    // Smallest w with 2**w >= n; n <= 1 yields 0 (caller must reject that)
    function automatic int unsigned ohwp_log2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/one_hot_decoder.sv
// Binary index to one-hot decoder (combinational).
// Ports:
//   index_i     in   INPUT_BW     binary slot index
//   encoding_o  out  OUTPUT_SIZE  one-hot of index_i
module one_hot_decoder #(
    parameter  int unsigned INPUT_BW    = 3,
    localparam int unsigned OUTPUT_SIZE = 1 << INPUT_BW
) (
    input  logic [INPUT_BW-1:0]    index_i,
    output logic [OUTPUT_SIZE-1:0] encoding_o
);

    always_comb begin
        encoding_o          = '0;
        encoding_o[index_i] = 1'b1;
    end

endmodule

// File: rtl/rotate_priority_select.sv
// Circular priority select: first request strictly after a one-hot start,
// wrapping around, with the start slot itself as the last candidate.
// Ports:
//   start_i         in   OUTPUT_SIZE  one-hot start position
//   req_i           in   OUTPUT_SIZE  request vector (1 = eligible)
//   grant_onehot_o  out  OUTPUT_SIZE  selected slot, one-hot (0 if none)
//   grant_index_o   out  INPUT_BW     selected slot, binary (0 if none)
//   found_o         out  1            some request was selected
//   wrapped_o       out  1            selected slot lies below the start slot
module rotate_priority_select #(
    parameter  int unsigned INPUT_BW    = 3,
    localparam int unsigned OUTPUT_SIZE = 1 << INPUT_BW
) (
    input  logic [OUTPUT_SIZE-1:0] start_i,
    input  logic [OUTPUT_SIZE-1:0] req_i,
    output logic [OUTPUT_SIZE-1:0] grant_onehot_o,
    output logic [INPUT_BW-1:0]    grant_index_o,
    output logic                   found_o,
    output logic                   wrapped_o
);

    localparam int unsigned DW = 2 * OUTPUT_SIZE;

    logic [DW-1:0] window;
    logic [DW-1:0] cand;
    logic          seen;

    // Scan window over {req, req}: lower copy covers slots after start,
    // upper copy covers slots up to and including start. With a one-hot
    // start, "start at or above k" is the complement of "start below k".
    always_comb begin
        window = '0;
        seen   = 1'b0;
        for (int unsigned p = 0; p < OUTPUT_SIZE; p++) begin
            window[p] = seen;
            seen      = seen | start_i[p];
        end
        for (int unsigned k = 0; k < OUTPUT_SIZE; k++) begin
            window[OUTPUT_SIZE + k] = ~window[k];
        end
        cand = {req_i, req_i} & window;
    end

    // Lowest set candidate wins; slot number is the position modulo size
    always_comb begin
        grant_onehot_o = '0;
        grant_index_o  = '0;
        found_o        = 1'b0;
        wrapped_o      = 1'b0;
        for (int unsigned p = 0; p < DW; p++) begin
            if (cand[p] && !found_o) begin
                found_o                               = 1'b1;
                grant_index_o                         = INPUT_BW'(p);
                grant_onehot_o[INPUT_BW'(p)]          = 1'b1;
                // Landing back on the start slot is a hold, not a wrap
                wrapped_o = (p >= OUTPUT_SIZE) && !start_i[INPUT_BW'(p)];
            end
        end
    end

endmodule

// File: rtl/one_hot_way_pointer.sv
// Registered one-hot / binary pointer over 2**INPUT_BW slots with load and
// circular advance to the next unmasked slot (round-robin victim pointer).
// Ports:
//   clock_i       in   1            rising-edge clock
//   reset_i       in   1            synchronous active-high reset
//   load_i        in   1            load pointer from load_index_i
//   load_index_i  in   INPUT_BW     binary slot to load
//   advance_i     in   1            step to next eligible slot
//   mask_i        in   OUTPUT_SIZE  1 = slot ineligible
//   encoding_o    out  OUTPUT_SIZE  pointer, one-hot, registered
//   index_o       out  INPUT_BW     pointer, binary, registered
//   valid_o       out  1            combinational: some slot unmasked
//   wrap_o        out  1            registered pulse: advance wrapped downward
module one_hot_way_pointer
    import one_hot_way_pointer_pkg::*;
#(
    parameter  int unsigned INPUT_BW    = OHWP_DEFAULT_INPUT_BW,
    parameter  int unsigned RESET_INDEX = 0,
    parameter  bit          SKIP_MASKED = 1'b1,
    localparam int unsigned OUTPUT_SIZE = 1 << INPUT_BW
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [INPUT_BW-1:0]    load_index_i,
    input  logic                   advance_i,
    input  logic [OUTPUT_SIZE-1:0] mask_i,
    output logic [OUTPUT_SIZE-1:0] encoding_o,
    output logic [INPUT_BW-1:0]    index_o,
    output logic                   valid_o,
    output logic                   wrap_o
);

    if (INPUT_BW == 0) begin : g_bad_input_bw
        $error("one_hot_way_pointer: INPUT_BW must be at least 1");
    end
    if (RESET_INDEX >= OUTPUT_SIZE) begin : g_bad_reset_index
        $error("one_hot_way_pointer: RESET_INDEX must be below OUTPUT_SIZE");
    end

    localparam logic [INPUT_BW-1:0]    RESET_IDX = INPUT_BW'(RESET_INDEX);
    localparam logic [OUTPUT_SIZE-1:0] RESET_ENC = OUTPUT_SIZE'(1) << RESET_INDEX;

    logic [OUTPUT_SIZE-1:0] encoding_q, encoding_d;
    logic [INPUT_BW-1:0]    index_q, index_d;
    logic                   wrap_q, wrap_d;

    logic [OUTPUT_SIZE-1:0] load_enc;
    logic [OUTPUT_SIZE-1:0] req;
    logic [OUTPUT_SIZE-1:0] adv_enc;
    logic [INPUT_BW-1:0]    adv_idx;
    logic                   adv_found;
    logic                   adv_wrapped;

    one_hot_decoder #(
        .INPUT_BW (INPUT_BW)
    ) u_load_dec (
        .index_i    (load_index_i),
        .encoding_o (load_enc)
    );

    // Without skipping every slot requests, so the select degenerates to +1
    assign req = SKIP_MASKED ? ~mask_i : '1;

    rotate_priority_select #(
        .INPUT_BW (INPUT_BW)
    ) u_next_sel (
        .start_i        (encoding_q),
        .req_i          (req),
        .grant_onehot_o (adv_enc),
        .grant_index_o  (adv_idx),
        .found_o        (adv_found),
        .wrapped_o      (adv_wrapped)
    );

    // Next-state priority mux: load over advance over hold
    always_comb begin
        encoding_d = encoding_q;
        index_d    = index_q;
        wrap_d     = 1'b0;
        if (load_i) begin
            encoding_d = load_enc;
            index_d    = load_index_i;
        end else if (advance_i && adv_found) begin
            encoding_d = adv_enc;
            index_d    = adv_idx;
            wrap_d     = adv_wrapped;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            encoding_q <= RESET_ENC;
            index_q    <= RESET_IDX;
            wrap_q     <= 1'b0;
        end else begin
            encoding_q <= encoding_d;
            index_q    <= index_d;
            wrap_q     <= wrap_d;
        end
    end

    assign encoding_o = encoding_q;
    assign index_o    = index_q;
    assign wrap_o     = wrap_q;
    assign valid_o    = ~&mask_i;

endmodule
